// File: rtl/seqdet_pkg.sv
// Shared types, defaults and helpers for the programmable sequence detector.
package seqdet_pkg;

    localparam int unsigned MAX_LEN_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic {
        UNCONF = 1'b0,
        ARMED  = 1'b1
    } state_t;

    // A pattern length is usable only when it is 1..max_len.
    function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
        return (len >= 32'd1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Serial-stream, pattern-config and status bundle of the sequence detector.
interface seq_detector_prog_if
    import seqdet_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               inp;
    logic               in_valid;
    logic               overlap;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_data;
    logic [LEN_W-1:0]   pat_len;

    logic               match;
    logic               armed;
    logic               cfg_err;
    logic [LEN_W-1:0]   fill;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output inp, in_valid, overlap, pat_load, pat_data, pat_len,
        input  match, armed, cfg_err, fill, match_count
    );

    modport slave (
        input  inp, in_valid, overlap, pat_load, pat_data, pat_len,
        output match, armed, cfg_err, fill, match_count
    );

endinterface

// File: rtl/seqdet_history.sv
// Serial history shift register with a saturating count of valid history bits.
module seqdet_history #(
    parameter  int unsigned MAX_LEN = 8,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic               consume,
    output logic [MAX_LEN-1:0] hist_shift_c,
    output logic [LEN_W-1:0]   fill_inc_c,
    output logic [LEN_W-1:0]   fill
);

    // Only MAX_LEN-1 bits are stored: the oldest stored bit becomes the
    // top of the post-shift window, and the bit beyond it is never compared.
    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    always_comb begin
        hist_shift_c = {hist_q, bit_in};
        fill_inc_c   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_shift_c[MAX_LEN-2:0];
            fill_q <= consume ? '0 : fill_inc_c;
        end
    end

    assign fill = fill_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector with registered match pulse.
// Define SEQDET_COUNT_EN to build the saturating match counter.
module seq_detector_prog
    import seqdet_pkg::*;
#(
    parameter  int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter  int unsigned CNT_W   = CNT_W_DEF,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic clk,
    input  logic reset,
    seq_detector_prog_if.slave bus
);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               match_q;
    logic               cfg_err_q, cfg_err_d;
    logic               armed_q;

    logic               load_ok_c;
    logic               shift_en_c;
    logic               hit_c;
    logic               consume_c;
    logic [MAX_LEN-1:0] mask_c;
    logic [MAX_LEN-1:0] hist_shift_c;
    logic [LEN_W-1:0]   fill_inc_c;
    logic [LEN_W-1:0]   fill;

    // A load in the same cycle as a valid bit wins; that bit is dropped.
    assign load_ok_c  = bus.pat_load && len_legal(32'(bus.pat_len), MAX_LEN);
    assign shift_en_c = bus.in_valid && !bus.pat_load;

    seqdet_history #(
        .MAX_LEN (MAX_LEN)
    ) u_history (
        .clk          (clk),
        .rst_n        (reset),
        .clear        (bus.pat_load),
        .shift_en     (shift_en_c),
        .bit_in       (bus.inp),
        .consume      (consume_c),
        .hist_shift_c (hist_shift_c),
        .fill_inc_c   (fill_inc_c),
        .fill         (fill)
    );

    // Next-state, pattern capture and load-error decode.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        cfg_err_d = 1'b0;

        case (state_q)
            UNCONF:  if (load_ok_c) state_d = ARMED;
            ARMED:   state_d = ARMED;
            default: state_d = UNCONF;
        endcase

        if (load_ok_c) begin
            pat_d = bus.pat_data;
            len_d = bus.pat_len;
        end else if (bus.pat_load) begin
            cfg_err_d = 1'b1;
        end
    end

    // Masked compare of the post-shift window against the active pattern.
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask_c[i] = (i < 32'(len_q));
        end
        hit_c = shift_en_c
             && (state_q == ARMED)
             && (fill_inc_c >= len_q)
             && (((hist_shift_c ^ pat_q) & mask_c) == '0);
        consume_c = hit_c && !bus.overlap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= UNCONF;
            pat_q     <= '0;
            len_q     <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            match_q   <= hit_c;
            cfg_err_q <= cfg_err_d;
            armed_q   <= (state_d == ARMED);
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // Saturating count of hits; survives pattern reloads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (hit_c && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.match_count = count_q;
`else
    assign bus.match_count = '0;
`endif

    assign bus.match   = match_q;
    assign bus.cfg_err = cfg_err_q;
    assign bus.armed   = armed_q;
    assign bus.fill    = fill;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed, table-driven bench for seq_detector_prog (8-bit and 2-bit counter instances).
module tb_seq_detector_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic inp;
        logic valid;
        logic exp_match;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               inp;
    logic               in_valid;
    logic               overlap;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_data;
    logic [LEN_W-1:0]   pat_len;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) bus_a ();
    seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) bus_b ();

    assign bus_a.inp      = inp;
    assign bus_a.in_valid = in_valid;
    assign bus_a.overlap  = overlap;
    assign bus_a.pat_load = pat_load;
    assign bus_a.pat_data = pat_data;
    assign bus_a.pat_len  = pat_len;
    assign bus_b.inp      = inp;
    assign bus_b.in_valid = in_valid;
    assign bus_b.overlap  = overlap;
    assign bus_b.pat_load = pat_load;
    assign bus_b.pat_data = pat_data;
    assign bus_b.pat_len  = pat_len;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a.slave)
    );

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_sat (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n, input int w);
        int sat;
        int r;
        sat = (1 << w) - 1;
        r   = (n > sat) ? sat : n;
`ifndef SEQDET_COUNT_EN
        r = 0;
`endif
        return 32'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        inp      = 1'b0;
        in_valid = 1'b0;
        pat_load = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] d, input logic [LEN_W-1:0] l);
        pat_data = d;
        pat_len  = l;
        pat_load = 1'b1;
        tick();
        pat_load = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic push_stream(input logic [19:0] bits, input logic [19:0] hits);
        for (int i = 19; i >= 0; i--) begin
            tbl.push_back('{inp: bits[i], valid: 1'b1, exp_match: hits[i]});
        end
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            inp      = tbl[i].inp;
            in_valid = tbl[i].valid;
            tick();
            check($sformatf("%s_a[%0d]", name, i), 32'(bus_a.match), 32'(tbl[i].exp_match));
            check($sformatf("%s_b[%0d]", name, i), 32'(bus_b.match), 32'(tbl[i].exp_match));
        end
        in_valid = 1'b0;
        tbl.delete();
    endtask

    task automatic check_idle(input string name);
        check({name, "_match"}, 32'(bus_a.match), 32'd0);
        check({name, "_armed"}, 32'(bus_a.armed), 32'd0);
        check({name, "_cfg_err"}, 32'(bus_a.cfg_err), 32'd0);
        check({name, "_fill"}, 32'(bus_a.fill), 32'd0);
        check({name, "_count"}, 32'(bus_a.match_count), 32'd0);
    endtask

    localparam logic [19:0] STREAM  = 20'b11101101001001101101;
    localparam logic [19:0] HIT_OV  = 20'b00001001000000001001;
    localparam logic [19:0] HIT_NOV = 20'b00001000000000001000;

    initial begin
        logic [MAX_LEN-1:0] p8;
        rst_n    = 1'b0;
        inp      = 1'b0;
        in_valid = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_data = '0;
        pat_len  = '0;

        // Reset state, before and after the first edge under reset.
        #2;
        check_idle("rst0");
        tick();
        check_idle("rst1");
        rst_n = 1'b1;

        // Overlapping 1101; the load also carries a valid bit that must be dropped.
        inp      = 1'b1;
        in_valid = 1'b1;
        load(8'h0D, 4'd4);
        check("load_armed", 32'(bus_a.armed), 32'd1);
        check("load_cfg_err", 32'(bus_a.cfg_err), 32'd0);
        check("load_fill", 32'(bus_a.fill), 32'd0);
        overlap = 1'b1;
        push_stream(STREAM, HIT_OV);
        run_table("ov");
        check("ov_count", 32'(bus_a.match_count), cnt_exp(4, 8));
        check("ov_fill", 32'(bus_a.fill), 32'd8);

        // Reload restarts detection but keeps the count.
        load(8'h0D, 4'd4);
        check("reload_count", 32'(bus_a.match_count), cnt_exp(4, 8));
        check("reload_fill", 32'(bus_a.fill), 32'd0);

        // Non-overlapping on the same stream.
        do_reset();
        load(8'h0D, 4'd4);
        overlap = 1'b0;
        push_stream(STREAM, HIT_NOV);
        run_table("nov");
        check("nov_count", 32'(bus_a.match_count), cnt_exp(2, 8));
        check("nov_fill", 32'(bus_a.fill), 32'd3);

        // Illegal lengths are rejected and nothing is ever detected.
        do_reset();
        overlap = 1'b1;
        load(8'h0D, 4'd0);
        check("len0_cfg_err", 32'(bus_a.cfg_err), 32'd1);
        check("len0_armed", 32'(bus_a.armed), 32'd0);
        tick();
        check("len0_pulse", 32'(bus_a.cfg_err), 32'd0);
        load(8'h0D, 4'(MAX_LEN + 1));
        check("len9_cfg_err", 32'(bus_a.cfg_err), 32'd1);
        check("len9_armed", 32'(bus_a.armed), 32'd0);
        push_stream(STREAM, 20'd0);
        run_table("unconf");
        check("unconf_armed", 32'(bus_a.armed), 32'd0);
        check("unconf_count", 32'(bus_a.match_count), 32'd0);

        // A rejected load in ARMED keeps the old pattern but clears history.
        load(8'h0D, 4'd4);
        inp = 1'b1;
        in_valid = 1'b1;
        tick();
        check("pre_bad_fill", 32'(bus_a.fill), 32'd1);
        load(8'h00, 4'd0);
        check("bad_cfg_err", 32'(bus_a.cfg_err), 32'd1);
        check("bad_armed", 32'(bus_a.armed), 32'd1);
        check("bad_fill", 32'(bus_a.fill), 32'd0);
        tbl.push_back('{inp: 1'b1, valid: 1'b1, exp_match: 1'b0});
        tbl.push_back('{inp: 1'b1, valid: 1'b1, exp_match: 1'b0});
        tbl.push_back('{inp: 1'b0, valid: 1'b1, exp_match: 1'b0});
        tbl.push_back('{inp: 1'b1, valid: 1'b1, exp_match: 1'b1});
        tbl.push_back('{inp: 1'b1, valid: 1'b0, exp_match: 1'b0});
        run_table("keep");
        check("keep_count", 32'(bus_a.match_count), cnt_exp(1, 8));

        // Full-length pattern with invalid gap cycles carrying inverted garbage.
        do_reset();
        p8 = 8'b10110011;
        load(p8, 4'd8);
        for (int k = 0; k < 8; k++) begin
            tbl.push_back('{inp: p8[7-k], valid: 1'b1, exp_match: (k == 7)});
            tbl.push_back('{inp: ~p8[7-k], valid: 1'b0, exp_match: 1'b0});
        end
        run_table("gap");
        check("gap_count", 32'(bus_a.match_count), cnt_exp(1, 8));
        check("gap_fill", 32'(bus_a.fill), 32'd8);

        // Single-bit pattern: one match per bit, 2-bit counter saturates.
        do_reset();
        load(8'h01, 4'd1);
        check("sat_armed_b", 32'(bus_b.armed), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tbl.push_back('{inp: 1'b1, valid: 1'b1, exp_match: 1'b1});
        end
        run_table("sat");
        check("sat_count_a", 32'(bus_a.match_count), cnt_exp(5, 8));
        check("sat_count_b", 32'(bus_b.match_count), cnt_exp(5, 2));

        // Reset after three of four bits; the last bit alone must not match.
        do_reset();
        load(8'h0D, 4'd4);
        tbl.push_back('{inp: 1'b1, valid: 1'b1, exp_match: 1'b0});
        tbl.push_back('{inp: 1'b1, valid: 1'b1, exp_match: 1'b0});
        tbl.push_back('{inp: 1'b0, valid: 1'b1, exp_match: 1'b0});
        run_table("mid");
        check("mid_fill", 32'(bus_a.fill), 32'd3);
        rst_n = 1'b0;
        #1;
        check_idle("mid_rst");
        tick();
        check_idle("mid_rst_edge");
        rst_n    = 1'b1;
        inp      = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_match", 32'(bus_a.match), 32'd0);
        check("post_rst_armed", 32'(bus_a.armed), 32'd0);
        tick();
        check("post_rst_armed2", 32'(bus_a.armed), 32'd0);
        load(8'h0D, 4'd4);
        check("rearm", 32'(bus_a.armed), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
